// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl
//   Match sequencer for the two-paddle VGA ball game. Sits next to the
//   display/motion block on the 25 MHz pixel clock and drives the motion
//   datapath through its speed input and a ball re-centre strobe. It watches
//   the datapath's lose flags and vsync to count points, ramp the rally speed
//   and declare a winner.
//
// Parameters
//   WIN_SCORE     points needed to win (1..15)
//   SERVE_FRAMES  frames held in SERVE before the automatic launch
//   POINT_FRAMES  frames held in POINT to show the scored point
//   BASE_SPEED    rally speed at launch
//   MAX_SPEED     rally speed ceiling (BASE_SPEED..15)
//   RAMP_FRAMES   play frames between +1 speed steps
//
// Ports
//   clk             25 MHz pixel clock
//   rst             synchronous reset, active low
//   vs              vsync, active-low pulse once per frame
//   lose1 / lose2   level: bottom / top bar missed the ball
//   start           debounced start/serve button level
//   bar_move_speed  per-frame motion step for the datapath, 0 = frozen
//   ball_reset      one-cycle strobe, re-centres the ball
//   score1 / score2 player points
//   winner          00 none, 01 player 1, 10 player 2
//   state_o         current state encoding (LEDs / debug)

module pong_match_ctrl #(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int BASE_SPEED   = 2,
  parameter int MAX_SPEED    = 8,
  parameter int RAMP_FRAMES  = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vs,
  input  logic       lose1,
  input  logic       lose2,
  input  logic       start,
  output logic [3:0] bar_move_speed,
  output logic       ball_reset,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] winner,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  // frame_cnt is shared by SERVE and POINT, so it is sized for the longer hold
  localparam int FRM_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int FW      = (FRM_MAX > 1) ? $clog2(FRM_MAX) : 1;
  localparam int RW      = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;

  localparam logic [FW-1:0] SERVE_LAST = FW'(SERVE_FRAMES - 1);
  localparam logic [FW-1:0] POINT_LAST = FW'(POINT_FRAMES - 1);
  localparam logic [RW-1:0] RAMP_LAST  = RW'(RAMP_FRAMES - 1);
  localparam logic [3:0]    WIN        = 4'(WIN_SCORE);
  localparam logic [3:0]    BASE       = 4'(BASE_SPEED);
  localparam logic [3:0]    MAXS       = 4'(MAX_SPEED);

  state_t        state;
  logic [FW-1:0] frame_cnt;
  logic [RW-1:0] ramp_cnt;
  logic [3:0]    speed;

  // input history; vs idles high so its history resets to 1
  logic vs_q, lose1_q, lose2_q, start_q;
  logic tick;

  logic start_rise, lose1_rise, lose2_rise;
  logic [3:0] speed_up;

  // rising edges compare the live input against last cycle's sample
  assign start_rise = start & ~start_q;
  assign lose1_rise = lose1 & ~lose1_q;
  assign lose2_rise = lose2 & ~lose2_q;

  assign speed_up = (speed >= MAXS) ? MAXS : speed + 4'd1;

  assign state_o = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      frame_cnt      <= '0;
      ramp_cnt       <= '0;
      speed          <= '0;
      bar_move_speed <= '0;
      ball_reset     <= 1'b0;
      score1         <= '0;
      score2         <= '0;
      winner         <= 2'b00;
      vs_q           <= 1'b1;
      lose1_q        <= 1'b0;
      lose2_q        <= 1'b0;
      start_q        <= 1'b0;
      tick           <= 1'b0;
    end else begin
      vs_q    <= vs;
      lose1_q <= lose1;
      lose2_q <= lose2;
      start_q <= start;
      // frame tick: vs seen high last cycle and low now, registered
      tick    <= vs_q & ~vs;

      // ball_reset only rises on the transitions into SERVE below
      ball_reset <= 1'b0;

      case (state)
        IDLE: begin
          bar_move_speed <= '0;
          if (start_rise) begin
            score1     <= '0;
            score2     <= '0;
            winner     <= 2'b00;
            frame_cnt  <= '0;
            ball_reset <= 1'b1;
            state      <= SERVE;
          end
        end

        SERVE: begin
          bar_move_speed <= '0;
          // a start press launches early; otherwise launch on the last frame
          if (start_rise || (tick && frame_cnt == SERVE_LAST)) begin
            speed          <= BASE;
            bar_move_speed <= BASE;
            ramp_cnt       <= '0;
            state          <= PLAY;
          end else if (tick) begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end

        PLAY: begin
          if (lose1_rise || lose2_rise) begin
            // a simultaneous double miss voids the rally: nobody scores
            if (lose1_rise && !lose2_rise && score2 != WIN)
              score2 <= score2 + 4'd1;
            if (lose2_rise && !lose1_rise && score1 != WIN)
              score1 <= score1 + 4'd1;
            bar_move_speed <= '0;
            frame_cnt      <= '0;
            state          <= POINT;
          end else if (tick) begin
            if (ramp_cnt == RAMP_LAST) begin
              ramp_cnt       <= '0;
              speed          <= speed_up;
              bar_move_speed <= speed_up;
            end else begin
              ramp_cnt <= ramp_cnt + 1'b1;
            end
          end
        end

        POINT: begin
          bar_move_speed <= '0;
          if (tick) begin
            if (frame_cnt == POINT_LAST) begin
              frame_cnt <= '0;
              if (score1 == WIN) begin
                winner <= 2'b01;
                state  <= OVER;
              end else if (score2 == WIN) begin
                winner <= 2'b10;
                state  <= OVER;
              end else begin
                ball_reset <= 1'b1;
                state      <= SERVE;
              end
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end

        OVER: begin
          bar_move_speed <= '0;
          // back to IDLE only; a second press is needed to serve a new match
          if (start_rise)
            state <= IDLE;
        end

        default: begin
          bar_move_speed <= '0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
- Match sequencer for the two-paddle VGA ball game; runs on the 25 MHz pixel clock alongside the display/motion block.
- Gates and configures the shared ball/bar motion datapath through its speed input and a ball-reset strobe.
- Consumes the datapath's lose flags and vsync, counts points, ramps rally speed and declares a winner.

Parameters:
- WIN_SCORE, 7: points needed to win the match; legal range 1..15.
- SERVE_FRAMES, 60: frames held in SERVE before automatic launch.
- POINT_FRAMES, 90: frames held in POINT to show the scored point.
- BASE_SPEED, 2: bar_move_speed at launch.
- MAX_SPEED, 8: speed ceiling; must be >= BASE_SPEED and <= 15.
- RAMP_FRAMES, 300: play frames between +1 speed steps.

Ports:
- clk, in, 1: 25 MHz pixel clock.
- rst, in, 1: synchronous, active-low reset.
- vs, in, 1: vsync from the display block; active-low pulse, once per frame.
- lose1, in, 1: level; player 1 (bottom bar) missed the ball.
- lose2, in, 1: level; player 2 (top bar) missed the ball.
- start, in, 1: debounced level from the start/serve button.
- bar_move_speed, out, 4: motion step per frame for the datapath; 0 freezes motion.
- ball_reset, out, 1: one-cycle strobe to re-centre the ball at (330,390).
- score1, out, 4: player 1 points.
- score2, out, 4: player 2 points.
- winner, out, 2: 00 none, 01 player 1, 10 player 2.
- state_o, out, 3: current state encoding, for LEDs and debug.

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE; bar_move_speed=0; ball_reset=0; score1=score2=0; winner=00; all counters 0; registered vs/lose/start history = 1/0/0.
- Frame tick: a one-cycle internal pulse when vs registered high then low (falling edge). The tick is registered, so it lags the vs edge by 1 cycle.
- Edge detection: lose1, lose2 and start are each registered once. Rising edges (prev=0, cur=1) are evaluated every clk.
- State encodings: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4.
- IDLE: speed 0. On start rise: clear scores, set winner=00, go to SERVE.
- SERVE:
  - ball_reset=1 for exactly the first cycle in SERVE; frame_cnt cleared on entry; speed 0.
  - frame_cnt increments on each tick.
  - On frame_cnt==SERVE_FRAMES-1 with a tick, or on start rise (whichever comes first): go to PLAY, load speed=BASE_SPEED, clear ramp_cnt.
- PLAY:
  - bar_move_speed=current speed.
  - Each tick increments ramp_cnt. When ramp_cnt reaches RAMP_FRAMES-1 at a tick, ramp_cnt wraps to 0 and speed increments, saturating at MAX_SPEED.
  - lose1 rise only: score2+1, go to POINT.
  - lose2 rise only: score1+1, go to POINT.
  - Both rise in the same cycle: no score change, go to POINT (void rally).
  - Lose edges are ignored in all other states.
- POINT:
  - Speed 0; frame_cnt cleared on entry.
  - After POINT_FRAMES ticks: if score1==WIN_SCORE, winner=01 and go to OVER; else if score2==WIN_SCORE, winner=10 and go to OVER; else go to SERVE.
  - Scores never exceed WIN_SCORE; increments use 4-bit arithmetic with no wrap possible.
- OVER: speed 0; scores and winner hold. On start rise: go to IDLE, then immediately to SERVE on a later start rise (two presses per new match).
- A start rise in PLAY or POINT is ignored.
- Reset mid-operation: any state returns to IDLE within the same edge, and an in-flight ball_reset is dropped.
- bar_move_speed, ball_reset and winner are registered outputs; no combinational path runs from inputs to outputs.

Test Plan:
- Reset with rst=0 for 3 clks in PLAY at speed 5 -> next cycle state_o=0, bar_move_speed=0, score1=score2=0, winner=00.
- Bench params SERVE_FRAMES=3, BASE_SPEED=2, with start pulsed in IDLE -> ball_reset high for 1 cycle; PLAY entered 1 cycle after the 3rd vs falling edge, with bar_move_speed=2.
- In PLAY with RAMP_FRAMES=4, BASE_SPEED=2, MAX_SPEED=4, run 20 frames -> speed follows 2,3,4,4,4, stepping on frames 4 and 8.
- lose1 and lose2 rise on the same clk in PLAY -> scores unchanged, state_o=3; then SERVE after POINT_FRAMES, with ball_reset pulsed.
- WIN_SCORE=2: lose2 rises twice across rallies -> score1=2; after the POINT hold, winner=01, state_o=4, speed 0; a later lose1 rise leaves score2=0.
- lose1 held high across POINT and SERVE into PLAY without a new rising edge -> no extra point; a start rise during PLAY -> no state change.
